// File: rtl/tt_gpio_cfg_seq.sv
// Runtime pad configuration sequencer: serially loaded shadow words, applied to
// the pads atomically through a SAFE -> LOAD -> SETTLE sequence.
module tt_gpio_cfg_seq #(
   parameter int                          N_PADS      = 44,
   parameter int                          CFG_W       = 16,
   parameter logic [N_PADS*CFG_W-1:0]     DEFAULT_CFG = {N_PADS{16'h0001}},
   parameter logic [CFG_W-1:0]            SAFE_CFG    = 16'b0_00_00_1_0_0_0_0_0_0_0_000,
   parameter int                          SETTLE_CYC  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_din,
   input  logic                           cfg_shift,
   output logic                           cfg_dout,
   input  logic                           cfg_apply,
   input  logic                           cfg_lock_req,
   output logic [N_PADS*CFG_W-1:0]        pad_cfg,
   output logic                           busy,
   output logic                           locked
);
   localparam int               TOT_W    = N_PADS * CFG_W;
   localparam int               CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SAFE, ST_LOAD, ST_SETTLE} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TOT_W-1:0]   shadow_q, shadow_d;
   logic [TOT_W-1:0]   snap_q, snap_d;
   logic [TOT_W-1:0]   pad_q, pad_d;
   logic               busy_q, busy_d;
   logic               locked_q, locked_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      snap_d   = snap_q;
      pad_d    = pad_q;
      shadow_d = cfg_shift ? {shadow_q[TOT_W-2:0], cfg_din} : shadow_q;
      locked_d = locked_q | cfg_lock_req;

      case (state_q)
         ST_IDLE: begin
            // Snapshot takes the pre-shift shadow, so a same-cycle shift is not included
            if (cfg_apply && !locked_q) begin
               snap_d  = shadow_q;
               pad_d   = {N_PADS{SAFE_CFG}};
               cnt_d   = CNT_INIT;
               state_d = ST_SAFE;
            end
         end
         ST_SAFE: begin
            if (cnt_q == '0) state_d = ST_LOAD;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_LOAD: begin
            pad_d   = snap_q;
            cnt_d   = CNT_INIT;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shadow_q <= DEFAULT_CFG;
         snap_q   <= DEFAULT_CFG;
         pad_q    <= DEFAULT_CFG;
         busy_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         snap_q   <= snap_d;
         pad_q    <= pad_d;
         busy_q   <= busy_d;
         locked_q <= locked_d;
      end
   end

   assign cfg_dout = shadow_q[TOT_W-1];
   assign pad_cfg  = pad_q;
   assign busy     = busy_q;
   assign locked   = locked_q;

endmodule

// File: doc/tt_gpio_cfg_seq.md
Name: tt_gpio_cfg_seq

Overview:
Runtime-programmable pad configuration sequencer for the openframe GPIO ring, generalised over pad count and config word width. It holds a serially loaded shadow copy of every pad's config word, with per-bit fields matching the tt_gpio CONFIG word. On command it applies the shadow atomically through a safe-state sequence: all pads are parked in SAFE_CFG, then the new words are driven. It sits between the control pads (ctrl[*]) and the per-pad tt_gpio instances, and replaces the fixed CONFIG localparam with a reset default plus a reconfigurable path.

Parameters:
N_PADS, 44, number of pads handled
CFG_W, 16, config bits per pad
DEFAULT_CFG, all TT_PAD_IN words (N_PADS*CFG_W bits), value of shadow and pad_cfg at reset; pad i uses bits [CFG_W*i +: CFG_W]
SAFE_CFG, 16'b0_00_00_1_0_0_0_0_0_0_0_000, word driven to every pad during the SAFE phase (input disabled, dm=000 high-Z)
SETTLE_CYC, 4, cycles spent in SAFE and in SETTLE; legal range >=1

Ports:
clk  in  1  system clock
rst  in  1  reset
cfg_din  in  1  serial config data bit
cfg_shift  in  1  shift strobe; one bit per cycle in which it is high
cfg_dout  out  1  serial readback, shadow MSB
cfg_apply  in  1  apply-request pulse
cfg_lock_req  in  1  sticky lock request
pad_cfg  out  N_PADS*CFG_W  active per-pad config words to tt_gpio instances
busy  out  1  apply sequence in progress
locked  out  1  configuration frozen

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: shadow=DEFAULT_CFG, pad_cfg=DEFAULT_CFG, snapshot=DEFAULT_CFG, state=IDLE, busy=0, locked=0, counter=0, cfg_dout=DEFAULT_CFG MSB. Reset asserted mid-sequence aborts the sequence; pad_cfg returns to DEFAULT_CFG on the next edge.
- Shift register:
  - When cfg_shift=1: shadow <= {shadow[N_PADS*CFG_W-2:0], cfg_din}.
  - cfg_dout = shadow[N_PADS*CFG_W-1], combinational from the register.
  - After N_PADS*CFG_W shifts, the first bit shifted in sits at pad N_PADS-1, bit CFG_W-1.
  - Shifting is allowed in every state and while locked. It never affects pad_cfg directly.
- FSM states: IDLE, SAFE, LOAD, SETTLE.
- IDLE:
  - If cfg_apply=1 and locked=0, capture snapshot <= shadow, using the pre-shift value if cfg_shift is also high that cycle.
  - Set pad_cfg <= SAFE_CFG replicated N_PADS times, counter <= SETTLE_CYC-1, go to SAFE.
  - Otherwise hold.
- SAFE: if counter=0 go to LOAD; else counter-1.
- LOAD: pad_cfg <= snapshot, counter <= SETTLE_CYC-1, go to SETTLE. Single cycle.
- SETTLE: if counter=0 go to IDLE; else counter-1.
- busy: high in every state except IDLE, registered together with the state.
- Timing: for cfg_apply sampled at edge t:
  - pad_cfg=SAFE_CFG from t+1 through t+SETTLE_CYC+1.
  - pad_cfg=snapshot from t+SETTLE_CYC+2.
  - busy high from t+1, low from t+2*SETTLE_CYC+2.
- cfg_apply while busy=1: ignored, not queued.
- Lock:
  - cfg_lock_req=1 sets locked on the next edge; only rst clears it.
  - An in-progress sequence completes normally.
  - cfg_apply and cfg_lock_req both high in IDLE with locked=0: the apply is accepted and locked is set.
  - While locked=1, cfg_apply is ignored.
- Counter width: $clog2(SETTLE_CYC+1) bits; no wrap occurs within a legal range.

Test Plan:
- Reset defaults: assert rst 2 cycles -> pad_cfg==DEFAULT_CFG, busy=0, locked=0; 704 shifts with cfg_din=0 -> cfg_dout replays DEFAULT_CFG MSB-first, pad_cfg unchanged.
- Full load and apply (N_PADS=44, SETTLE_CYC=4): shift 704 bits making pad 31 = 16'b0_11_00_1_0_0_0_0_0_0_0_110 and all others 16'b0_00_00_1_0_0_0_0_0_0_0_000, pulse cfg_apply at edge t -> pad_cfg all SAFE_CFG for t+1..t+5, new words at t+6, busy low at t+10.
- Apply during busy and shift during apply: second cfg_apply at t+3 -> ignored, busy still falls at t+10. Shifting 16 bits during SAFE -> pad_cfg at t+6 equals the snapshot from t, not the shifted shadow.
- Lock: cfg_lock_req with cfg_apply in the same IDLE cycle -> sequence runs, locked=1. Later cfg_apply -> busy stays 0, pad_cfg unchanged. Shifting still updates cfg_dout.
- Reset mid-sequence: rst during SETTLE -> next edge pad_cfg=DEFAULT_CFG, busy=0, locked=0, shadow=DEFAULT_CFG.
- SETTLE_CYC=1 build: cfg_apply at t -> SAFE_CFG at t+1..t+2, new words at t+3, busy low at t+4.
